// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: EX/MEM and MEM/WB bus widths, field positions,
// the memory-stage FSM states and the MEM/WB packing helper.
package pipe_pkg;

    localparam int EXMEM_W = 133;
    localparam int MEMWB_W = 71;

    // EX/MEM bus field positions
    localparam int EX_ZERO      = 0;
    localparam int EX_REGWRITE  = 1;
    localparam int EX_MEMTOREG  = 2;
    localparam int EX_MEMWRITE  = 3;
    localparam int EX_BRANCHEQ  = 4;
    localparam int EX_JUMP      = 5;
    localparam int EX_WREG_LSB  = 6;
    localparam int EX_WREG_MSB  = 10;
    localparam int EX_ALU_LSB   = 11;
    localparam int EX_ALU_MSB   = 42;
    localparam int EX_WDATA_LSB = 43;
    localparam int EX_WDATA_MSB = 74;
    localparam int EX_PCBR_LSB  = 75;
    localparam int EX_PCBR_MSB  = 106;
    localparam int EX_PCJ_LSB   = 107;
    localparam int EX_PCJ_MSB   = 132;

    // MEM/WB bus field positions
    localparam int WB_REGWRITE  = 0;
    localparam int WB_MEMTOREG  = 1;
    localparam int WB_WREG_LSB  = 2;
    localparam int WB_WREG_MSB  = 6;
    localparam int WB_ALU_LSB   = 7;
    localparam int WB_ALU_MSB   = 38;
    localparam int WB_RDATA_LSB = 39;
    localparam int WB_RDATA_MSB = 70;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    function automatic logic [MEMWB_W-1:0] pack_memwb(
        input logic        reg_write,
        input logic        mem_to_reg,
        input logic [4:0]  write_reg,
        input logic [31:0] alu_out,
        input logic [31:0] read_data
    );
        logic [MEMWB_W-1:0] bus;
        bus                             = {MEMWB_W{1'b0}};
        bus[WB_REGWRITE]                = reg_write;
        bus[WB_MEMTOREG]                = mem_to_reg;
        bus[WB_WREG_MSB:WB_WREG_LSB]    = write_reg;
        bus[WB_ALU_MSB:WB_ALU_LSB]      = alu_out;
        bus[WB_RDATA_MSB:WB_RDATA_LSB]  = read_data;
        return bus;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts WAIT cycles without a memory acknowledge and flags the last allowed one.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          expire_s;

    assign expire_s = en_i & (cnt_q == LAST);
    assign expire_o = expire_s;

    // Next count: clear on WAIT entry, hold once the limit is hit
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = {CW{1'b0}};
        end else if (en_i && !expire_s) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: unpacks EX/MEM, runs loads/stores over a req/ack data port,
// stalls upstream while an access is outstanding and registers MEM/WB.
module mem_access_unit
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [EXMEM_W-1:0]  in,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [31:0]         dmem_addr,
    output logic [31:0]         dmem_wdata,
    input  logic                dmem_ack,
    input  logic [31:0]         dmem_rdata,
    output logic                stall,
    output logic                redirect,
    output logic [31:0]         redirect_pc,
    output logic                flushCtrl,
    output logic [MEMWB_W-1:0]  out,
    output logic                dmem_err
);

    logic        zero_s;
    logic        reg_write_s;
    logic        mem_to_reg_s;
    logic        mem_write_s;
    logic        branch_eq_s;
    logic        jump_s;
    logic [4:0]  write_reg_s;
    logic [31:0] alu_out_s;
    logic [31:0] write_data_s;
    logic [31:0] pc_branch_s;
    logic [25:0] pc_jump_s;

    assign zero_s       = in[EX_ZERO];
    assign reg_write_s  = in[EX_REGWRITE];
    assign mem_to_reg_s = in[EX_MEMTOREG];
    assign mem_write_s  = in[EX_MEMWRITE];
    assign branch_eq_s  = in[EX_BRANCHEQ];
    assign jump_s       = in[EX_JUMP];
    assign write_reg_s  = in[EX_WREG_MSB:EX_WREG_LSB];
    assign alu_out_s    = in[EX_ALU_MSB:EX_ALU_LSB];
    assign write_data_s = in[EX_WDATA_MSB:EX_WDATA_LSB];
    assign pc_branch_s  = in[EX_PCBR_MSB:EX_PCBR_LSB];
    assign pc_jump_s    = in[EX_PCJ_MSB:EX_PCJ_LSB];

    mem_state_e         state_q;
    mem_state_e         state_d;
    logic               dmem_req_q;
    logic               dmem_req_d;
    logic               dmem_we_q;
    logic               dmem_we_d;
    logic               dmem_err_q;
    logic               dmem_err_d;
    logic [MEMWB_W-1:0] out_q;
    logic [MEMWB_W-1:0] out_d;

    logic        memop_s;
    logic        load_s;
    logic        retire_s;
    logic        expire_s;
    logic        ctr_clear_s;
    logic        ctr_en_s;
    logic        wb_reg_write_s;
    logic [31:0] read_data_s;

    // A combined MemWrite+MemToReg behaves as a store that writes no register
    assign memop_s        = mem_write_s | mem_to_reg_s;
    assign load_s         = mem_to_reg_s & ~mem_write_s;
    assign wb_reg_write_s = reg_write_s & ~(mem_write_s & mem_to_reg_s);

    assign ctr_clear_s = (state_q == IDLE) & memop_s;
    assign ctr_en_s    = (state_q == WAIT) & ~dmem_ack;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i    (clk),
        .clr_i    (clr),
        .clear_i  (ctr_clear_s),
        .en_i     (ctr_en_s),
        .expire_o (expire_s)
    );

    // Stall decode: entry cycle of a memop, then every WAIT cycle until ack or expiry
    always_comb begin
        stall = 1'b0;
        case (state_q)
            IDLE:    stall = memop_s;
            WAIT:    stall = ~dmem_ack & ~expire_s;
            default: stall = 1'b0;
        endcase
    end

    assign retire_s    = ~stall;
    assign redirect    = retire_s & ((branch_eq_s & zero_s) | jump_s);
    assign flushCtrl   = redirect;
    assign redirect_pc = jump_s ? {pc_branch_s[31:28], pc_jump_s, 2'b00} : pc_branch_s;

    assign dmem_addr  = alu_out_s;
    assign dmem_wdata = write_data_s;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_err   = dmem_err_q;
    assign out        = out_q;

    // FSM next state, request controls, load data selection and retire bus
    always_comb begin
        state_d     = state_q;
        dmem_req_d  = dmem_req_q;
        dmem_we_d   = dmem_we_q;
        dmem_err_d  = dmem_err_q;
        read_data_s = 32'h0000_0000;
        case (state_q)
            IDLE: begin
                if (memop_s) begin
                    state_d    = WAIT;
                    dmem_req_d = 1'b1;
                    dmem_we_d  = mem_write_s;
                end else begin
                    state_d    = IDLE;
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    state_d     = IDLE;
                    dmem_req_d  = 1'b0;
                    dmem_we_d   = 1'b0;
                    read_data_s = load_s ? dmem_rdata : 32'h0000_0000;
                end else if (expire_s) begin
                    state_d    = IDLE;
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    dmem_err_d = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d    = IDLE;
                dmem_req_d = 1'b0;
                dmem_we_d  = 1'b0;
            end
        endcase

        if (retire_s) begin
            out_d = pack_memwb(wb_reg_write_s, mem_to_reg_s, write_reg_s, alu_out_s, read_data_s);
        end else begin
            out_d = {MEMWB_W{1'b0}};
        end
    end

    // State and registered outputs; clr aborts any outstanding access
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= IDLE;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            dmem_err_q <= 1'b0;
            out_q      <= {MEMWB_W{1'b0}};
        end else begin
            state_q    <= state_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            dmem_err_q <= dmem_err_d;
            out_q      <= out_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus a randomized
// back-to-back stream checked against a transaction-level reference model.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         clr;
    logic [132:0] in_b;
    logic         dmem_req, dmem_we, dmem_ack;
    logic [31:0]  dmem_addr, dmem_wdata, dmem_rdata;
    logic         stall, redirect, flushCtrl, dmem_err;
    logic [31:0]  redirect_pc;
    logic [70:0]  out_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit err_exp  = 1'b0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .clr         (clr),
        .in          (in_b),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .flushCtrl   (flushCtrl),
        .out         (out_b),
        .dmem_err    (dmem_err)
    );

    function automatic logic [132:0] mk_bus(input bit zero, input bit rw, input bit mtr,
                                            input bit mw, input bit beq, input bit jmp,
                                            input logic [4:0] wreg, input logic [31:0] alu,
                                            input logic [31:0] wdata, input logic [31:0] pcb,
                                            input logic [25:0] pcj);
        return {pcj, pcb, wdata, alu, wreg, jmp, beq, mw, mtr, rw, zero};
    endfunction

    // Reference: what writeback should see for one instruction
    function automatic logic [70:0] exp_out(input logic [132:0] bus, input bit acked,
                                            input logic [31:0] rd);
        bit          mw, mtr;
        logic [31:0] rdv;
        mw  = bus[3];
        mtr = bus[2];
        rdv = (mtr && !mw && acked) ? rd : 32'h0;
        return {rdv, bus[42:11], bus[10:6], mtr, bus[1] & ~(mw & mtr)};
    endfunction

    function automatic logic [31:0] exp_pc(input logic [132:0] bus);
        logic [31:0] pcb;
        pcb = bus[106:75];
        return bus[5] ? {pcb[31:28], bus[132:107], 2'b00} : pcb;
    endfunction

    // Drives one instruction and plays memory: ack on the (k+1)th request cycle, never if k<0
    task automatic exec(input logic [132:0] bus, input int k, input logic [31:0] rd,
                        output int stalls, output int reqs, output int redirs,
                        output logic [31:0] rpc, output bit stable_ok, output bit bubble_ok,
                        output bit flush_ok, output logic [70:0] got);
        int it;
        bit done;
        in_b = bus;
        stalls = 0; reqs = 0; redirs = 0; rpc = 32'h0;
        stable_ok = 1'b1; bubble_ok = 1'b1; flush_ok = 1'b1;
        done = 1'b0; it = 0;
        while (!done) begin
            if (dmem_req === 1'b1) begin
                reqs++;
                dmem_ack = (k >= 0) && (reqs == k + 1);
            end else begin
                dmem_ack = 1'b0;
            end
            dmem_rdata = dmem_ack ? rd : $urandom();
            @(negedge clk);
            if (dmem_req === 1'b1 && (dmem_addr !== bus[42:11] || dmem_wdata !== bus[74:43]
                                      || dmem_we !== bus[3]))
                stable_ok = 1'b0;
            if (it > 0 && out_b !== 71'h0) bubble_ok = 1'b0;
            if (flushCtrl !== redirect) flush_ok = 1'b0;
            if (redirect === 1'b1) begin
                redirs++;
                rpc = redirect_pc;
            end
            if (stall === 1'b0) done = 1'b1;
            else stalls++;
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            it++;
            if (!done && it > 200) begin
                n_checks++; n_fail++;
                $display("FAIL exec_bound: got no retire after %0d cycles, expected within %0d", it, TO + 1);
                done = 1'b1;
            end
        end
        got = out_b;
    endtask

    task automatic test_reset();
        clr = 1'b1; in_b = 133'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        @(posedge clk); #1;
        in_b = mk_bus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0000_1000, 26'h0);
        @(negedge clk);
        n_checks++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL reset_comb_redirect: got %b expected 1", redirect); end
        @(posedge clk); #1;
        clr = 1'b0; in_b = 133'h0;
        @(negedge clk);
        n_checks++; if (out_b !== 71'h0) begin n_fail++; $display("FAIL reset_out: got %h expected 0", out_b); end
        n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", dmem_req); end
        n_checks++; if (dmem_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", dmem_err); end
        n_checks++; if (stall !== 1'b0 || redirect !== 1'b0) begin n_fail++; $display("FAIL reset_bubble: got stall=%b redirect=%b expected 0 0", stall, redirect); end
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        int s, r, rd_n; logic [31:0] rpc; bit so, bo, fo; logic [70:0] got;
        exec(mk_bus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 32'h1234, $urandom(), $urandom(), 26'h0),
             0, 32'h0, s, r, rd_n, rpc, so, bo, fo, got);
        n_checks++; if (s != 0) begin n_fail++; $display("FAIL alu_stall: got %0d expected 0", s); end
        n_checks++; if (got !== {32'h0, 32'h1234, 5'd5, 1'b0, 1'b1}) begin n_fail++; $display("FAIL alu_out: got %h expected %h", got, {32'h0, 32'h1234, 5'd5, 1'b0, 1'b1}); end
    endtask

    task automatic test_load();
        int s, r, rd_n; logic [31:0] rpc; bit so, bo, fo; logic [70:0] got;
        exec(mk_bus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'h100, 32'h0, 32'h0, 26'h0),
             3, 32'hDEAD_BEEF, s, r, rd_n, rpc, so, bo, fo, got);
        n_checks++; if (s != 4) begin n_fail++; $display("FAIL load_stall: got %0d expected 4", s); end
        n_checks++; if (r != 4) begin n_fail++; $display("FAIL load_req_cycles: got %0d expected 4", r); end
        n_checks++; if (!so) begin n_fail++; $display("FAIL load_addr_we: got unstable/wrong req fields expected addr=100 we=0"); end
        n_checks++; if (!bo) begin n_fail++; $display("FAIL load_bubble: got nonzero out during stall expected 0"); end
        n_checks++; if (got[70:39] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_rdata: got %h expected deadbeef", got[70:39]); end
    endtask

    task automatic test_store();
        int s, r, rd_n; logic [31:0] rpc; bit so, bo, fo; logic [70:0] got;
        logic [132:0] bus;
        exec(mk_bus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 32'h40, 32'hCAFE, 32'h0, 26'h0),
             0, 32'h5555_AAAA, s, r, rd_n, rpc, so, bo, fo, got);
        n_checks++; if (s != 1 || r != 1) begin n_fail++; $display("FAIL store_stall: got stall=%0d req=%0d expected 1 1", s, r); end
        n_checks++; if (!so) begin n_fail++; $display("FAIL store_req_fields: got wrong we/addr/wdata expected we=1 addr=40 wdata=cafe"); end
        n_checks++; if (got[0] !== 1'b0 || got[70:39] !== 32'h0) begin n_fail++; $display("FAIL store_out: got %h expected RegWrite=0 readData=0", got); end
        // Both MemWrite and MemToReg: a store that must not write the register file
        bus = mk_bus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'h80, 32'h77, 32'h0, 26'h0);
        exec(bus, 1, 32'h1111_2222, s, r, rd_n, rpc, so, bo, fo, got);
        n_checks++; if (got !== exp_out(bus, 1'b1, 32'h1111_2222) || got[0] !== 1'b0) begin n_fail++; $display("FAIL store_mtr_out: got %h expected %h", got, exp_out(bus, 1'b1, 32'h1111_2222)); end
        n_checks++; if (!so) begin n_fail++; $display("FAIL store_mtr_we: got load request expected store"); end
    endtask

    task automatic test_branch();
        int s, r, rd_n; logic [31:0] rpc; bit so, bo, fo; logic [70:0] got;
        exec(mk_bus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0040_0020, 26'h0),
             0, 32'h0, s, r, rd_n, rpc, so, bo, fo, got);
        n_checks++; if (rd_n != 1 || !fo) begin n_fail++; $display("FAIL branch_taken: got redirects=%0d flush_ok=%0b expected 1 1", rd_n, fo); end
        n_checks++; if (rpc !== 32'h0040_0020) begin n_fail++; $display("FAIL branch_pc: got %h expected 00400020", rpc); end
        exec(mk_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0040_0020, 26'h0),
             0, 32'h0, s, r, rd_n, rpc, so, bo, fo, got);
        n_checks++; if (rd_n != 0) begin n_fail++; $display("FAIL branch_not_taken: got redirects=%0d expected 0", rd_n); end
    endtask

    task automatic test_jump();
        int s, r, rd_n; logic [31:0] rpc; bit so, bo, fo; logic [70:0] got;
        exec(mk_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'h0, 32'h0, 32'h8000_0000, 26'h10),
             0, 32'h0, s, r, rd_n, rpc, so, bo, fo, got);
        n_checks++; if (rd_n != 1) begin n_fail++; $display("FAIL jump_redirect: got %0d expected 1", rd_n); end
        n_checks++; if (rpc !== 32'h8000_0040) begin n_fail++; $display("FAIL jump_pc: got %h expected 80000040", rpc); end
    endtask

    task automatic test_ack_idle();
        in_b = mk_bus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 32'h99, 32'h0, 32'h0, 26'h0);
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ack_idle_stall: got %b expected 0", stall); end
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        n_checks++; if (out_b[70:39] !== 32'h0 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL ack_idle_out: got rdata=%h req=%b expected 0 0", out_b[70:39], dmem_req); end
    endtask

    task automatic test_timeout();
        int s, r, rd_n; logic [31:0] rpc; bit so, bo, fo; logic [70:0] got;
        exec(mk_bus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'h200, 32'h0, 32'h0, 26'h0),
             -1, 32'h0, s, r, rd_n, rpc, so, bo, fo, got);
        err_exp = 1'b1;
        n_checks++; if (s != TO || r != TO) begin n_fail++; $display("FAIL timeout_cycles: got stall=%0d req=%0d expected %0d %0d", s, r, TO, TO); end
        n_checks++; if (got[70:39] !== 32'h0) begin n_fail++; $display("FAIL timeout_rdata: got %h expected 0", got[70:39]); end
        n_checks++; if (dmem_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b expected 1", dmem_err); end
        exec(mk_bus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 32'h5, 32'h0, 32'h0, 26'h0),
             0, 32'h0, s, r, rd_n, rpc, so, bo, fo, got);
        n_checks++; if (dmem_err !== 1'b1 || s != 0) begin n_fail++; $display("FAIL timeout_sticky: got err=%b stall=%0d expected 1 0", dmem_err, s); end
    endtask

    task automatic test_clr_wait();
        in_b = mk_bus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 32'h300, 32'h0, 32'h0, 26'h0);
        dmem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL clr_wait_pre: got req=%b expected 1", dmem_req); end
        clr = 1'b1; in_b = 133'h0;
        @(posedge clk); #1;
        clr = 1'b0;
        err_exp = 1'b0;
        @(negedge clk);
        n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL clr_wait_req: got %b expected 0", dmem_req); end
        n_checks++; if (dmem_err !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL clr_wait_err: got err=%b stall=%b expected 0 0", dmem_err, stall); end
        @(posedge clk); #1;
    endtask

    // Back-to-back random instructions, each checked against the transaction model
    task automatic test_back_to_back();
        int s, r, rd_n, k, kr, exp_cyc; logic [31:0] rpc, rd; bit so, bo, fo, memop, exp_red;
        logic [70:0] got, exp; logic [132:0] bus;
        for (int i = 0; i < 60; i++) begin
            bus = mk_bus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                         5'($urandom()), $urandom(), $urandom(), $urandom(), 26'($urandom()));
            kr = $urandom_range(0, TO);
            k  = (kr == TO) ? -1 : kr;
            rd = $urandom();
            memop   = bus[3] | bus[2];
            exp_cyc = memop ? ((k >= 0) ? k + 1 : TO) : 0;
            exp_red = (bus[4] & bus[0]) | bus[5];
            exp     = exp_out(bus, memop && (k >= 0), rd);
            if (memop && k < 0) err_exp = 1'b1;
            exec(bus, k, rd, s, r, rd_n, rpc, so, bo, fo, got);
            n_checks++; if (s != exp_cyc || r != exp_cyc) begin n_fail++; $display("FAIL b2b_cycles[%0d]: got stall=%0d req=%0d expected %0d", i, s, r, exp_cyc); end
            n_checks++; if (got !== exp) begin n_fail++; $display("FAIL b2b_out[%0d]: got %h expected %h", i, got, exp); end
            n_checks++; if (rd_n != int'(exp_red) || !fo) begin n_fail++; $display("FAIL b2b_redirect[%0d]: got %0d flush_ok=%0b expected %0d", i, rd_n, fo, exp_red); end
            if (exp_red) begin
                n_checks++; if (rpc !== exp_pc(bus)) begin n_fail++; $display("FAIL b2b_pc[%0d]: got %h expected %h", i, rpc, exp_pc(bus)); end
            end
            n_checks++; if (!so || !bo) begin n_fail++; $display("FAIL b2b_req_bubble[%0d]: got stable=%0b bubble=%0b expected 1 1", i, so, bo); end
            n_checks++; if (dmem_err !== err_exp) begin n_fail++; $display("FAIL b2b_err[%0d]: got %b expected %b", i, dmem_err, err_exp); end
        end
        in_b = 133'h0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_branch();
        test_jump();
        test_ack_idle();
        test_timeout();
        test_clr_wait();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage consumer of the packed 133-bit EX/MEM bus. Unpacks the bus and runs loads and stores against a multi-cycle data memory through a req/ack handshake. Stalls upstream while an access is outstanding, resolves branch/jump into a PC redirect plus a flush, and registers a packed 71-bit MEM/WB bus for the writeback stage.

## Interface
Parameters:
- TIMEOUT, 64: cycles without dmem_ack before the access is declared failed.

Ports:
- clk  in  1  pipeline clock; everything samples on posedge.
- clr  in  1  reset; synchronous, active-high.
- in  in  133  EX/MEM bus. Field layout:
  - [0] zero, [1] RegWrite, [2] MemToReg, [3] MemWrite, [4] BranchEq, [5] Jump
  - [10:6] writeReg, [42:11] alu_out, [74:43] writeData, [106:75] pcBranch, [132:107] pcJump
- dmem_req  out  1  data memory request, registered.
- dmem_we  out  1  1 = store, 0 = load. Valid while dmem_req is high.
- dmem_addr  out  32  equals alu_out.
- dmem_wdata  out  32  equals writeData.
- dmem_ack  in  1  one-cycle completion pulse from memory.
- dmem_rdata  in  32  load data. Valid in the cycle dmem_ack is high.
- stall  out  1  combinational; upstream holds PC, IF/ID, ID/EX and EX/MEM while high.
- redirect  out  1  combinational; branch taken or jump, at retirement.
- redirect_pc  out  32  redirect target.
- flushCtrl  out  1  equals redirect; drives the EX/MEM and ID/EX flush inputs.
- out  out  71  MEM/WB bus. Field layout:
  - [0] RegWrite, [1] MemToReg, [6:2] writeReg, [38:7] alu_out, [70:39] readData
- dmem_err  out  1  sticky timeout flag.

## Operation
- memop = MemWrite | MemToReg. If both are set, the access is a store, no load is issued, and the retired RegWrite is forced to 0.
- FSM, two states:
  - IDLE: if memop, assert stall and go to WAIT. Otherwise the instruction retires this cycle.
  - WAIT: dmem_req = 1 and dmem_we = MemWrite. The request stays high with stable address/data until ack.
    - On dmem_ack, capture dmem_rdata, go to IDLE, deassert stall; the instruction retires this cycle.
    - Without ack, stall stays high and the timeout counter increments.
    - When the counter reaches TIMEOUT-1 with no ack, set dmem_err, go to IDLE and retire with readData = 0. The store or load is considered lost.
- Retire happens in a cycle with stall = 0:
  - out <= packed fields. readData is dmem_rdata for loads, 0 otherwise.
  - redirect = (BranchEq & zero) | Jump.
  - Jump has priority: redirect_pc = {pcBranch[31:28], pcJump, 2'b00}. Otherwise redirect_pc = pcBranch.
- Stall cycles: out <= 0, which is a bubble. redirect = 0. Branches are never resolved twice.
- All-zero input bus is a bubble: no memop, no redirect, retires zeros.
- The timeout counter clears on every IDLE→WAIT entry.

## Timing
- Reset values: state IDLE, dmem_req 0, out 0, dmem_err 0, counter 0. Combinational outputs follow the input bus.
- Non-memory instruction: appears on `in` in cycle N, out is valid in N+1, redirect/flushCtrl is asserted in N.
- Load/store with memory acking k cycles after the first dmem_req cycle:
  - cycle N is IDLE with stall high.
  - dmem_req is high from N+1 through N+1+k.
  - ack arrives at N+1+k and out is valid at N+2+k.
  - Total stall is k+1 cycles (0-wait memory: k = 0, one stall cycle).
- dmem_ack while in IDLE is ignored.
- clr during WAIT: the FSM aborts to IDLE on that edge and dmem_req is low the next cycle. Memory must tolerate a dropped request.
- dmem_err is cleared only by clr.

## Structure
- Shared package (pipe_pkg) holds:
  - EXMEM_W = 133 and MEMWB_W = 71;
  - all field LSB/MSB constants for both buses, also used by the EX/MEM and MEM/WB registers;
  - the FSM state enum {IDLE, WAIT}.
- One sub-module: mem_timeout_ctr, a clog2(TIMEOUT)-bit counter with clear, enable and expire outputs.
- Unpacking, FSM and retirement register stay in the top.

## Test plan
- ALU op, RegWrite = 1, writeReg = 5, alu_out = 0x1234, no memop → stall stays 0; next cycle out has RegWrite = 1, writeReg = 5, alu_out = 0x1234, readData = 0.
- Load, alu_out = 0x100, memory acks after 3 cycles with rdata = 0xDEADBEEF:
  - stall is high 4 cycles; dmem_addr = 0x100 and dmem_we = 0 throughout;
  - out readData = 0xDEADBEEF.
- Store, writeData = 0xCAFE, addr 0x40, 0-wait memory → dmem_we = 1, dmem_wdata = 0xCAFE; stall for exactly 1 cycle; out RegWrite = 0.
- BranchEq = 1, zero = 1, pcBranch = 0x00400020 → redirect = flushCtrl = 1 and redirect_pc = 0x00400020 in the same cycle. With zero = 0, redirect = 0.
- Jump = 1, pcJump = 0x0000010, pcBranch = 0x80000000 → redirect_pc = 0x80000040.
- No ack for TIMEOUT = 4 cycles → dmem_err goes high and stays high, the FSM returns to IDLE, out readData = 0. clr mid-WAIT drops dmem_req the next cycle.
